// File: rtl/query_seq_mem.sv
// ----------------------------------------------------------------------------
// query_seq_mem
//   Simple dual-port RAM that holds the query sequence for the Smith-Waterman
//   datapath. Port A is write-only (filled by the sequence loader). Port B is
//   read-only and feeds query words to the systolic array.
//
//   A per-word written-flag array masks words that were never written since
//   reset, so they read back as zero. The data array itself is never reset,
//   which keeps it inferable as block RAM.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   wea    - port A write enable
//   addra  - port A write address
//   dina   - port A write data
//   addrb  - port B read address (sampled every rising edge)
//   doutb  - port B read data, registered (latency 1, or 2 with QSM_OUTREG_EN)
//
// Optional feature macro: QSM_OUTREG_EN
//   Adds a second asynchronously reset output register (read latency 2).
// ----------------------------------------------------------------------------
module query_seq_mem #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q, written_d;

    // Raw RAM read register (no reset, block RAM style) plus the flag that
    // qualifies it. The flag register is reset asynchronously, so the masked
    // output drops to zero the moment rst_n falls.
    logic [DATA_W-1:0] rd_word_q, rd_word_d;
    logic              rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] stage1;

    always_comb begin
        written_d = written_q;
        if (wea) begin
            written_d[addra] = 1'b1;
        end
        // Both reads see pre-write state, which gives read-first collisions.
        rd_vld_d  = written_q[addrb];
        rd_word_d = mem_q[addrb];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            written_q <= written_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    // Data array and its read register are deliberately unreset; writes are
    // gated by rst_n so nothing lands while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wea) begin
                mem_q[addra] <= dina;
            end
            rd_word_q <= rd_word_d;
        end
    end

    assign stage1 = rd_vld_q ? rd_word_q : '0;

`ifdef QSM_OUTREG_EN
    logic [DATA_W-1:0] out_q, out_d;

    always_comb begin
        out_d = stage1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign doutb = out_q;
`else
    assign doutb = stage1;
`endif

endmodule

// File: tb/tb_query_seq_mem.sv
// ----------------------------------------------------------------------------
// tb_query_seq_mem
//   Self-checking bench for query_seq_mem. Each driven cycle computes the
//   expected read result from a reference model (read-first) and pushes it to
//   a scoreboard queue tagged with the cycle it is due; after every edge the
//   due entries are popped and compared against doutb.
// ----------------------------------------------------------------------------
module tb_query_seq_mem;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef QSM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wea = 1'b0;
    logic [ADDR_W-1:0] addra = '0;
    logic [DATA_W-1:0] dina = '0;
    logic [ADDR_W-1:0] addrb = '0;
    logic [DATA_W-1:0] doutb;

    query_seq_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .addrb (addrb),
        .doutb (doutb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] val;
        string             nm;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mdl_mem [DEPTH];
    bit                mdl_wr  [DEPTH];
    int                cyc    = 0;
    int                checks = 0;
    int                errors = 0;

    localparam logic [DATA_W-1:0] PAT_A = {8{16'hAAAA}};
    localparam logic [DATA_W-1:0] PAT_5 = {8{16'h5555}};

    // Drive one cycle; expectation is taken from the model before the write
    // is applied, so same-address collisions expect the old contents.
    task automatic do_cycle(input logic we, input logic [ADDR_W-1:0] wa,
                            input logic [DATA_W-1:0] wd,
                            input logic [ADDR_W-1:0] ra, input string nm);
        exp_t e;
        wea   = we;
        addra = wa;
        dina  = wd;
        addrb = ra;
        e.due = cyc + LAT;
        e.nm  = nm;
        e.val = (rst_n && mdl_wr[ra]) ? mdl_mem[ra] : '0;
        sb.push_back(e);
        if (rst_n && we) begin
            mdl_mem[wa] = wd;
            mdl_wr[wa]  = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (doutb !== e.val) begin
                errors++;
                $display("FAIL %s: doutb=%h expected %h", e.nm, doutb, e.val);
            end
        end
    endtask

    task automatic flush();
        for (int i = 0; i < LAT + 1; i++) do_cycle(1'b0, '0, '0, '0, "flush");
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_wr[i] = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (doutb !== '0) begin
            errors++;
            $display("FAIL reset_immediate: doutb=%h expected 0", doutb);
        end
        do_cycle(1'b0, '0, '0, '0, "reset_held_rd0");
        do_cycle(1'b0, '0, '0, 10'd3, "reset_held_rd3");
        #2 rst_n = 1'b1;
        do_cycle(1'b0, '0, '0, '0, "post_reset_rd0");
        flush();
    endtask

    task automatic test_basic_write_read();
        do_cycle(1'b1, 10'd0, 128'd10, 10'd7, "basic_wr");
        do_cycle(1'b0, '0, '0, 10'd0, "basic_rd0");
        flush();
    endtask

    task automatic test_boundary();
        do_cycle(1'b1, 10'd1023, PAT_A, 10'd0, "bnd_wr1023");
        do_cycle(1'b1, 10'd1, PAT_5, 10'd0, "bnd_wr1");
        do_cycle(1'b0, '0, '0, 10'd1023, "bnd_rd1023");
        do_cycle(1'b0, '0, '0, 10'd1, "bnd_rd1");
        do_cycle(1'b0, '0, '0, 10'd0, "bnd_rd0");
        do_cycle(1'b0, '0, '0, 10'd2, "bnd_rd2_unwritten");
        flush();
    endtask

    task automatic test_collision();
        do_cycle(1'b1, 10'd5, 128'h11, 10'd0, "col_prep");
        do_cycle(1'b1, 10'd5, 128'h22, 10'd5, "col_readfirst");
        do_cycle(1'b0, '0, '0, 10'd5, "col_after");
        // collision on a never-written word must return zero
        do_cycle(1'b1, 10'd9, 128'h99, 10'd9, "col_unwritten");
        do_cycle(1'b0, '0, '0, 10'd9, "col_unwritten_after");
        flush();
    endtask

    task automatic test_back_to_back();
        do_cycle(1'b1, 10'd6, 128'hA1, 10'd6, "b2b_w1");
        do_cycle(1'b1, 10'd6, 128'hA2, 10'd6, "b2b_w2");
        do_cycle(1'b1, 10'd6, 128'hA3, 10'd6, "b2b_w3");
        do_cycle(1'b0, '0, '0, 10'd6, "b2b_rd");
        flush();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] wa, ra;
        logic [DATA_W-1:0] wd;
        for (int i = 0; i < 60; i++) begin
            wa = ADDR_W'($urandom_range(0, 7));
            ra = ADDR_W'($urandom_range(0, 7));
            if (i % 7 == 0) wa = 10'd1023;
            if (i % 5 == 0) ra = 10'd1023;
            wd = {$urandom, $urandom, $urandom, $urandom};
            do_cycle(1'(($urandom_range(0, 1))), wa, wd, ra, "random");
        end
        flush();
    endtask

    task automatic test_reset_mid();
        do_cycle(1'b1, 10'd0, 128'd10, 10'd0, "mid_rewrite0");
        do_cycle(1'b0, '0, '0, 10'd0, "mid_rd0_before");
        flush();
        // doutb now shows address 0 (value 10); drop reset between edges
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (doutb !== '0) begin
            errors++;
            $display("FAIL mid_reset_immediate: doutb=%h expected 0", doutb);
        end
        do_cycle(1'b1, 10'd0, 128'h77, 10'd0, "mid_wr_in_reset");
        do_cycle(1'b1, 10'd1023, 128'h78, 10'd1023, "mid_wr_in_reset2");
        #2 rst_n = 1'b1;
        do_cycle(1'b0, '0, '0, 10'd0, "mid_rd0_after");
        do_cycle(1'b0, '0, '0, 10'd1023, "mid_rd1023_after");
        do_cycle(1'b0, '0, '0, 10'd5, "mid_rd5_after");
        flush();
        do_cycle(1'b1, 10'd0, 128'h3C, 10'd0, "mid_rewrite");
        do_cycle(1'b0, '0, '0, 10'd0, "mid_rd_rewritten");
        flush();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mdl_wr[i]  = 1'b0;
            mdl_mem[i] = '0;
        end
        test_reset();
        test_basic_write_read();
        test_boundary();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
